// File: rtl/i2c_target.sv
// I2C target (peripheral) with a 7-bit address, one write byte stream and one read byte stream.
// Bus lines are oversampled by clk; SDA is only ever pulled low, never driven high.
module i2c_target #(
  parameter logic [6:0] kADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, WRITE, ACK_WR, READ, ACK_RD, IGNORE
  } state_t;

  state_t     state, state_next;
  logic       scl_p0, scl_p1, scl_p2;
  logic       sda_p0, sda_p1, sda_p2;
  logic [2:0] cnt, cnt_next;
  logic [7:0] sreg, sreg_next;
  logic [7:0] rx_data_next;
  logic       rw, rw_next;
  logic       phase, phase_next;
  logic       sda_low, sda_low_next;
  logic       rx_valid_next, tx_req_next;
  logic       scl_rise, scl_fall, start_det, stop_det;

  // Stage p0/p1: synchronizer; p2: edge-detect reference
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= SCL;    scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= SDA;    sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

  // Gating with rst lets reset float the line without waiting for a clock edge
  assign SDA = (sda_low && !rst) ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      sreg     <= 8'h00;
      rw       <= 1'b0;
      phase    <= 1'b0;
      sda_low  <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      sreg     <= sreg_next;
      rw       <= rw_next;
      phase    <= phase_next;
      sda_low  <= sda_low_next;
      rx_data  <= rx_data_next;
      rx_valid <= rx_valid_next;
      tx_req   <= tx_req_next;
      busy     <= state_next inside {ACK_ADDR, WRITE, ACK_WR, READ, ACK_RD};
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    sreg_next     = sreg;
    rw_next       = rw;
    phase_next    = phase;
    sda_low_next  = sda_low;
    rx_data_next  = rx_data;
    rx_valid_next = 1'b0;
    tx_req_next   = 1'b0;
    if (start_det) begin
      state_next   = ADDR;
      cnt_next     = 3'd0;
      sda_low_next = 1'b0;
    end else if (stop_det) begin
      state_next   = IDLE;
      sda_low_next = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          sreg_next = {sreg[6:0], sda_p1};
          cnt_next  = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (sreg[6:0] == kADDR) begin
              state_next = ACK_ADDR;
              rw_next    = sda_p1;
              phase_next = 1'b0;
            end else begin
              state_next = IGNORE;
            end
          end
        end
        // phase marks that the ACK low has already been driven for one falling edge
        ACK_ADDR: if (scl_fall) begin
          if (!phase) begin
            sda_low_next = 1'b1;
            phase_next   = 1'b1;
          end else if (rw) begin
            state_next   = READ;
            sreg_next    = tx_data;
            tx_req_next  = 1'b1;
            sda_low_next = ~tx_data[7];
            cnt_next     = 3'd0;
          end else begin
            state_next   = WRITE;
            sda_low_next = 1'b0;
            cnt_next     = 3'd0;
          end
        end
        WRITE: if (scl_rise) begin
          sreg_next = {sreg[6:0], sda_p1};
          cnt_next  = cnt + 3'd1;
          if (cnt == 3'd7) begin
            rx_data_next  = {sreg[6:0], sda_p1};
            rx_valid_next = 1'b1;
            state_next    = ACK_WR;
            phase_next    = 1'b0;
          end
        end
        ACK_WR: if (scl_fall) begin
          if (!phase) begin
            sda_low_next = 1'b1;
            phase_next   = 1'b1;
          end else begin
            sda_low_next = 1'b0;
            state_next   = WRITE;
          end
        end
        READ: if (scl_fall) begin
          sreg_next = {sreg[6:0], sreg[7]};
          cnt_next  = cnt + 3'd1;
          if (cnt == 3'd7) begin
            state_next   = ACK_RD;
            sda_low_next = 1'b0;
            phase_next   = 1'b0;
          end else begin
            sda_low_next = ~sreg[6];
          end
        end
        // Initiator ACK arms a reload on the following falling edge; NACK ends the read
        ACK_RD: begin
          if (scl_rise) begin
            if (sda_p1) state_next = IGNORE;
            else        phase_next = 1'b1;
          end else if (scl_fall && phase) begin
            state_next   = READ;
            sreg_next    = tx_data;
            tx_req_next  = 1'b1;
            sda_low_next = ~tx_data[7];
            cnt_next     = 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged initiator, directed vector table, hand-written corner
// sequences and randomized transactions compared against a transaction-level model.
module tb_i2c_target;

  localparam logic [6:0] ADDR = 7'h42;
  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_target #(.kADDR(ADDR)) dut (
    .clk(clk), .rst(rst), .SCL(scl), .SDA(sda),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] rx_q[$];
  int tx_cnt = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_req) tx_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0]  acks;
    logic [23:0] got;
    logic [23:0] rxd;
    logic [7:0]  nrx;
    logic [7:0]  ntx;
    logic        busy_any;
    logic        busy_end;
    logic        rel;
  } obs_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic        rw;
    logic [7:0]  n;
    logic [23:0] data;
    obs_t        exp;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_low = 1'b0; wait_clk(2*Q);
    scl = 1'b1;   wait_clk(Q);
    m_low = 1'b1; wait_clk(Q);
    scl = 1'b0;   wait_clk(1);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; wait_clk(2*Q);
    scl = 1'b1;   wait_clk(Q);
    m_low = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    m_low = ~b; wait_clk(2*Q);
    scl = 1'b1; wait_clk(Q);
    r = sda;    wait_clk(Q);
    scl = 1'b0; wait_clk(1);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    bus_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic recv_byte(output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
  endtask

  task automatic do_txn(input logic [6:0] a, input logic rw, input int n,
                        input logic [23:0] d, output obs_t o);
    int rx0, tx0, b0;
    logic ack, r;
    logic [7:0] byt;
    o = '0;
    rx0 = rx_q.size(); tx0 = tx_cnt; b0 = busy_cnt;
    tx_data = d[23:16];
    bus_start();
    send_byte({a, rw}, ack);
    o.acks[0] = ack;
    for (int i = 0; i < n; i++) begin
      if (!rw) begin
        send_byte(d[23-8*i -: 8], ack);
        o.acks[i+1] = ack;
      end else begin
        recv_byte(byt);
        o.got[23-8*i -: 8] = byt;
        if (i < n-1) tx_data = d[15-8*i -: 8];
        bus_bit(i == n-1, r);
      end
    end
    wait_clk(5);
    o.rel = sda;
    bus_stop();
    wait_clk(8);
    o.busy_end = busy;
    o.busy_any = (busy_cnt != b0);
    o.nrx = 8'(rx_q.size() - rx0);
    o.ntx = 8'(tx_cnt - tx0);
    for (int i = 0; i < int'(o.nrx) && i < 3; i++) o.rxd[23-8*i -: 8] = rx_q[rx0+i];
  endtask

  task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
    check({tag, ".acks"},     32'(a.acks),     32'(e.acks));
    check({tag, ".rd_data"},  32'(a.got),      32'(e.got));
    check({tag, ".rx_data"},  32'(a.rxd),      32'(e.rxd));
    check({tag, ".rx_valid"}, 32'(a.nrx),      32'(e.nrx));
    check({tag, ".tx_req"},   32'(a.ntx),      32'(e.ntx));
    check({tag, ".busy_any"}, 32'(a.busy_any), 32'(e.busy_any));
    check({tag, ".busy_end"}, 32'(a.busy_end), 32'(e.busy_end));
    check({tag, ".sda_rel"},  32'(a.rel),      32'(e.rel));
  endtask

  function automatic vec_t mkvec(logic [6:0] a, logic rw, logic [7:0] n, logic [23:0] d,
                                 logic [3:0] acks, logic [23:0] got, logic [23:0] rxd,
                                 logic [7:0] nrx, logic [7:0] ntx, logic bany);
    vec_t v;
    v.addr = a; v.rw = rw; v.n = n; v.data = d;
    v.exp.acks = acks; v.exp.got = got; v.exp.rxd = rxd;
    v.exp.nrx = nrx; v.exp.ntx = ntx; v.exp.busy_any = bany;
    v.exp.busy_end = 1'b0; v.exp.rel = 1'b1;
    return v;
  endfunction

  // Transaction-level expectation: a matching address is acknowledged along with every
  // written byte; a read returns the supplied bytes, otherwise the bus floats high.
  function automatic obs_t model(logic [6:0] a, logic rw, int n, logic [23:0] d);
    obs_t e;
    logic m;
    m = (a == ADDR);
    e = '0;
    e.acks[0] = m; e.busy_any = m; e.rel = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (rw) e.got[23-8*i -: 8] = m ? d[23-8*i -: 8] : 8'hFF;
      else begin
        e.acks[i+1] = m;
        if (m) e.rxd[23-8*i -: 8] = d[23-8*i -: 8];
      end
    end
    if (m && !rw) e.nrx = 8'(n);
    if (m && rw)  e.ntx = 8'(n);
    return e;
  endfunction

  vec_t vecs[6];

  initial begin
    obs_t o;
    logic ack, r, acc;
    logic [7:0] byt;
    int rx0;
    logic [6:0] ra;
    logic rrw;
    int rn;
    logic [23:0] rd;

    vecs[0] = mkvec(7'h42, 1'b0, 8'd3, 24'h0A193C, 4'b1111, 24'h0, 24'h0A193C, 8'd3, 8'd0, 1'b1);
    vecs[1] = mkvec(7'h42, 1'b1, 8'd2, 24'hA53C00, 4'b0001, 24'hA53C00, 24'h0, 8'd0, 8'd2, 1'b1);
    vecs[2] = mkvec(7'h43, 1'b0, 8'd1, 24'h550000, 4'b0000, 24'h0, 24'h0, 8'd0, 8'd0, 1'b0);
    vecs[3] = mkvec(7'h00, 1'b0, 8'd1, 24'hAA0000, 4'b0000, 24'h0, 24'h0, 8'd0, 8'd0, 1'b0);
    vecs[4] = mkvec(7'h42, 1'b0, 8'd1, 24'hFF0000, 4'b0011, 24'h0, 24'hFF0000, 8'd1, 8'd0, 1'b1);
    vecs[5] = mkvec(7'h43, 1'b1, 8'd1, 24'h120000, 4'b0000, 24'hFF0000, 24'h0, 8'd0, 8'd0, 1'b0);

    rst = 1'b1;
    wait_clk(3);
    check("rst.sda",      32'(sda),      32'd1);
    check("rst.rx_data",  32'(rx_data),  32'h00);
    check("rst.rx_valid", 32'(rx_valid), 32'd0);
    check("rst.tx_req",   32'(tx_req),   32'd0);
    check("rst.busy",     32'(busy),     32'd0);
    rst = 1'b0;
    wait_clk(5);

    for (int k = 0; k < 6; k++) begin
      do_txn(vecs[k].addr, vecs[k].rw, int'(vecs[k].n), vecs[k].data, o);
      cmp_obs($sformatf("vec%0d", k), o, vecs[k].exp);
    end

    // Write then repeated START into a read
    rx0 = rx_q.size();
    tx_data = 8'h5A;
    bus_start();
    send_byte(8'h84, ack); check("rs.addr_w_ack", 32'(ack), 32'd1);
    send_byte(8'h11, ack); check("rs.byte_ack",   32'(ack), 32'd1);
    bus_start();
    send_byte(8'h85, ack); check("rs.addr_r_ack", 32'(ack), 32'd1);
    check("rs.rx_data",  32'(rx_data), 32'h11);
    check("rs.rx_count", 32'(rx_q.size() - rx0), 32'd1);
    recv_byte(byt);        check("rs.read_data", 32'(byt), 32'h5A);
    bus_bit(1'b1, r);
    bus_stop(); wait_clk(8);
    check("rs.busy_end", 32'(busy), 32'd0);

    // Reset in the 5th bit of a read while the target pulls SDA low
    tx_data = 8'h00;
    bus_start();
    send_byte(8'h85, ack); check("rm.addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 4; i++) bus_bit(1'b1, r);
    m_low = 1'b0; wait_clk(Q);
    check("rm.sda_driven", 32'(sda), 32'd0);
    rst = 1'b1; #1;
    check("rm.sda_async_rel", 32'(sda),     32'd1);
    check("rm.busy",          32'(busy),    32'd0);
    check("rm.rx_data",       32'(rx_data), 32'h00);
    wait_clk(2); rst = 1'b0; wait_clk(Q);
    scl = 1'b1; wait_clk(Q); acc = sda; wait_clk(Q); scl = 1'b0; wait_clk(1);
    for (int i = 0; i < 4; i++) begin
      bus_bit(1'b1, r);
      acc = acc & r;
    end
    check("rm.ignored_bus", 32'(acc),  32'd1);
    check("rm.busy_after",  32'(busy), 32'd0);
    bus_stop(); wait_clk(4);
    do_txn(7'h42, 1'b0, 2, 24'h77C300, o);
    cmp_obs("rm.recover", o, model(7'h42, 1'b0, 2, 24'h77C300));

    // STOP after 4 bits of a write byte
    rx0 = rx_q.size();
    bus_start();
    send_byte(8'h84, ack); check("sp.addr_ack", 32'(ack), 32'd1);
    bus_bit(1'b1, r); bus_bit(1'b0, r); bus_bit(1'b1, r); bus_bit(1'b1, r);
    bus_stop(); wait_clk(8);
    check("sp.rx_count", 32'(rx_q.size() - rx0), 32'd0);
    check("sp.busy",     32'(busy), 32'd0);
    check("sp.sda_rel",  32'(sda),  32'd1);

    for (int k = 0; k < 10; k++) begin
      ra  = ($urandom_range(0, 2) == 0) ? 7'($urandom) : ADDR;
      rrw = 1'($urandom);
      rn  = int'($urandom_range(1, 3));
      rd  = 24'($urandom);
      do_txn(ra, rrw, rn, rd, o);
      cmp_obs($sformatf("rnd%0d", k), o, model(ra, rrw, rn, rd));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
